// File: rtl/relock_if.sv
// Signal bundle between a servo channel controller and the relock
// lock-loss detector / sweeper.
//   master : drives enable, sig_in, thresh, sweep_min, sweep_max, step;
//            observes relock_on, hold_i, sweep_out
//   slave  : the relock_ctrl side (mirror of master)
interface relock_if #(
  parameter int SIG_W = 14
) ();
  logic                    enable;
  logic signed [SIG_W-1:0] sig_in;
  logic signed [SIG_W-1:0] thresh;
  logic signed [SIG_W-1:0] sweep_min;
  logic signed [SIG_W-1:0] sweep_max;
  logic        [SIG_W-1:0] step;
  logic                    relock_on;
  logic                    hold_i;
  logic signed [SIG_W-1:0] sweep_out;

  modport master (
    output enable, sig_in, thresh, sweep_min, sweep_max, step,
    input  relock_on, hold_i, sweep_out
  );

  modport slave (
    input  enable, sig_in, thresh, sweep_min, sweep_max, step,
    output relock_on, hold_i, sweep_out
  );
endinterface

// File: rtl/relock_ctrl.sv
// Lock-loss detector and triangle-wave relock sweeper for one servo channel.
// The monitor signal is registered, compared against a threshold, and after
// DEBOUNCE consecutive low samples the block holds the servo integrator and
// sweeps an offset between sweep_min and sweep_max until the signal returns.
// Lock is declared again after DEBOUNCE consecutive good samples.
// Ports:
//   clk_in : system clock
//   rst_n  : synchronous active-low reset
//   bus    : relock_if.slave (enable, sig_in, thresh, sweep_min, sweep_max,
//            step in; relock_on, hold_i, sweep_out out)
module relock_ctrl #(
  parameter int SIG_W    = 14,
  parameter int DEBOUNCE = 1000,
  parameter int CNT_W    = 20
) (
  input  logic     clk_in,
  input  logic     rst_n,
  relock_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_SWEEP    = 2'd2,
    ST_SETTLE   = 2'd3
  } state_t;

  localparam logic             DIR_UP   = 1'b0;
  localparam logic             DIR_DOWN = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  // Two guard bits so even a full-scale unsigned step cannot wrap the sum.
  localparam int               EXT_W    = SIG_W + 2;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    dir_q;
  logic signed [SIG_W-1:0] sig_q;
  logic signed [SIG_W-1:0] sweep_q;
  logic                    relock_q;
  logic                    hold_q;

  logic                    below;
  logic signed [SIG_W-1:0] sweep_d;
  logic                    dir_d;
  logic signed [EXT_W-1:0] cur_x, min_x, max_x, step_x, up_x, dn_x;

  function automatic logic signed [EXT_W-1:0] sext(input logic signed [SIG_W-1:0] v);
    return EXT_W'(v);
  endfunction

  assign below = (sig_q < bus.thresh);

  // Next sweep point and direction, used only while in SWEEP.
  always_comb begin
    cur_x  = sext(sweep_q);
    min_x  = sext(bus.sweep_min);
    max_x  = sext(bus.sweep_max);
    step_x = $signed({2'b00, bus.step});
    up_x   = cur_x + step_x;
    dn_x   = cur_x - step_x;
    sweep_d = sweep_q;
    dir_d   = dir_q;
    if (min_x > max_x) begin
      // Inverted limits: park on sweep_min rather than sweeping garbage.
      sweep_d = bus.sweep_min;
    end else if (dir_q == DIR_UP) begin
      if (up_x >= max_x) begin
        sweep_d = bus.sweep_max;
        dir_d   = DIR_DOWN;
      end else begin
        sweep_d = up_x[SIG_W-1:0];
      end
    end else begin
      if (dn_x <= min_x) begin
        sweep_d = bus.sweep_min;
        dir_d   = DIR_UP;
      end else begin
        sweep_d = dn_x[SIG_W-1:0];
      end
    end
  end

  // State, counter and registered outputs all move on the same edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= ST_DISABLED;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      sig_q    <= '0;
      sweep_q  <= '0;
      relock_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      sig_q <= bus.sig_in;
      if (!bus.enable) begin
        state_q  <= ST_DISABLED;
        cnt_q    <= '0;
        dir_q    <= DIR_UP;
        sweep_q  <= '0;
        relock_q <= 1'b0;
        hold_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_DISABLED: begin
            state_q <= ST_LOCKED;
            cnt_q   <= '0;
          end
          ST_LOCKED: begin
            // sweep_q is left alone so the last lock offset is retained.
            if (below) begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= ST_SWEEP;
                cnt_q    <= '0;
                dir_q    <= DIR_UP;
                relock_q <= 1'b1;
                hold_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_q <= '0;
            end
          end
          ST_SWEEP: begin
            if (below) begin
              sweep_q <= sweep_d;
              dir_q   <= dir_d;
            end else begin
              // Freeze the offset where the signal came back.
              state_q <= ST_SETTLE;
              cnt_q   <= '0;
              hold_q  <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (!below) begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= ST_LOCKED;
                cnt_q    <= '0;
                relock_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              // Resume sweeping from the frozen point in the stored direction.
              state_q <= ST_SWEEP;
              cnt_q   <= '0;
              hold_q  <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_DISABLED;
            cnt_q    <= '0;
            relock_q <= 1'b0;
            hold_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.relock_on = relock_q;
  assign bus.hold_i    = hold_q;
  assign bus.sweep_out = sweep_q;

endmodule
